// File: rtl/vec_accel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vec_accel_pkg
// Description : Shared types and constants for the vector accumulate sequencer
// Revision    : 1.0 - initial release
// ============================================================================
package vec_accel_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LAUNCH  = 3'd1,
    COMPUTE = 3'd2,
    ACCUM   = 3'd3,
    FINISH  = 3'd4
  } seq_state_t;

  localparam logic [31:0] FP_ZERO     = 32'h0000_0000;
  localparam int          DEF_ADD_LAT = 3;
  localparam int          DEF_STRIDE  = 4;
  localparam int          DEF_CNT_W   = 16;

endpackage
`default_nettype wire

// File: rtl/fp_add.sv
`default_nettype none
// ============================================================================
// Module      : fp_add
// Description : float32 adder, round-to-nearest-even, denormals flushed to
//               zero, fixed LAT-cycle output pipeline
// Revision    : 1.0 - initial release
// ============================================================================
module fp_add #(
  parameter int LAT = 3
) (
  input  logic        clk,
  input  logic        areset,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] q
);

  logic [31:0] w_big, w_small, w_sum;
  logic [7:0]  w_diff;
  logic [27:0] w_m_big, w_m_sm, w_m_shift, w_m_al, w_m_sum;
  logic        w_sticky, w_round_up;
  logic [24:0] w_mant;
  int          w_exp;
  logic [31:0] r_pipe [LAT];

  // Align, add/subtract, normalise and round in a single combinational pass
  always_comb begin
    w_big   = a;
    w_small = b;
    if (b[30:0] > a[30:0]) begin
      w_big   = b;
      w_small = a;
    end
    w_m_big   = (w_big[30:23] == 8'd0)   ? 28'd0 : {2'b01, w_big[22:0], 3'b000};
    w_m_sm    = (w_small[30:23] == 8'd0) ? 28'd0 : {2'b01, w_small[22:0], 3'b000};
    w_diff    = w_big[30:23] - w_small[30:23];
    w_m_shift = w_m_sm >> w_diff;
    w_sticky  = ((w_m_shift << w_diff) != w_m_sm);
    w_m_al    = w_m_shift | {27'd0, w_sticky};
    w_exp     = int'(w_big[30:23]);
    if (w_big[31] == w_small[31]) w_m_sum = w_m_big + w_m_al;
    else                          w_m_sum = w_m_big - w_m_al;
    if (w_m_sum[27]) begin
      w_m_sum = {1'b0, w_m_sum[27:2], w_m_sum[1] | w_m_sum[0]};
      w_exp   = w_exp + 1;
    end else begin
      for (int i = 0; i < 26; i++) begin
        if ((w_m_sum != 28'd0) && !w_m_sum[26]) begin
          w_m_sum = w_m_sum << 1;
          w_exp   = w_exp - 1;
        end
      end
    end
    w_round_up = w_m_sum[2] & (w_m_sum[1] | w_m_sum[0] | w_m_sum[3]);
    w_mant     = {1'b0, w_m_sum[26:3]} + {24'd0, w_round_up};
    if (w_mant[24]) begin
      w_mant = w_mant >> 1;
      w_exp  = w_exp + 1;
    end
    if ((w_big[30:23] == 8'd0) || (w_m_sum == 28'd0) || (w_exp <= 0)) w_sum = 32'h0;
    else if (w_exp >= 255) w_sum = {w_big[31], 8'hFF, 23'd0};
    else                   w_sum = {w_big[31], 8'(w_exp), w_mant[22:0]};
  end

  // Delay line giving the fixed pipeline latency
  always_ff @(posedge clk) begin
    if (areset) begin
      for (int i = 0; i < LAT; i++) r_pipe[i] <= 32'h0;
    end else begin
      r_pipe[0] <= w_sum;
      for (int i = 1; i < LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign q = r_pipe[LAT-1];

endmodule
`default_nettype wire

// File: rtl/vec_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : vec_fetch_unit
// Description : Avalon-MM read master with one outstanding read and a
//               single-entry prefetch buffer
// Revision    : 1.0 - initial release
// ============================================================================
module vec_fetch_unit
  import vec_accel_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int STRIDE = DEF_STRIDE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] n_elem,
  input  logic             take,
  output logic [31:0]      avm_address,
  output logic             avm_read,
  input  logic             avm_waitrequest,
  input  logic [31:0]      avm_readdata,
  input  logic             avm_readdatavalid,
  output logic             buf_valid,
  output logic [31:0]      buf_data
);

  localparam logic [31:0] STRIDE_C = 32'(STRIDE);

  logic [CNT_W-1:0] r_fetch_cnt;
  logic             r_read;
  logic [31:0]      r_address;
  logic             r_outstanding;
  logic             r_buf_valid;
  logic [31:0]      r_buf_data;
  logic             w_accept;
  logic             w_issue;

  assign w_accept = r_read & ~avm_waitrequest;
  assign w_issue  = ~r_read & ~r_buf_valid & ~r_outstanding & ~clear &
                    (r_fetch_cnt < n_elem);

  // Request side: raise a read, hold it and its address until accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      r_read      <= 1'b0;
      r_address   <= 32'h0;
      r_fetch_cnt <= '0;
    end else if (clear) begin
      r_fetch_cnt <= '0;
    end else if (w_accept) begin
      r_read      <= 1'b0;
      r_fetch_cnt <= r_fetch_cnt + CNT_W'(1);
    end else if (w_issue) begin
      r_read      <= 1'b1;
      r_address   <= base_addr + 32'(r_fetch_cnt) * STRIDE_C;
    end
  end

  // Response side: only data matching our own outstanding read is kept
  always_ff @(posedge clk) begin
    if (reset) begin
      r_outstanding <= 1'b0;
      r_buf_valid   <= 1'b0;
      r_buf_data    <= 32'h0;
    end else begin
      if (w_accept) begin
        r_outstanding <= 1'b1;
      end else if (avm_readdatavalid && r_outstanding) begin
        r_outstanding <= 1'b0;
      end
      if (take) begin
        r_buf_valid <= 1'b0;
      end else if (avm_readdatavalid && r_outstanding) begin
        r_buf_valid <= 1'b1;
        r_buf_data  <= avm_readdata;
      end
    end
  end

  assign avm_read    = r_read;
  assign avm_address = r_address;
  assign buf_valid   = r_buf_valid;
  assign buf_data    = r_buf_data;

endmodule
`default_nettype wire

// File: rtl/vec_accel_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : vec_accel_sequencer
// Description : Sums f(x[i]) over a float32 vector in memory, feeding a scalar
//               accelerator and accumulating its results in order
// Revision    : 1.0 - initial release
// ============================================================================
module vec_accel_sequencer
  import vec_accel_pkg::*;
#(
  parameter int ADD_LAT = DEF_ADD_LAT,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int STRIDE  = DEF_STRIDE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] n_elem,
  output logic             done,
  output logic [31:0]      result,
  output logic [31:0]      avm_address,
  output logic             avm_read,
  input  logic             avm_waitrequest,
  input  logic [31:0]      avm_readdata,
  input  logic             avm_readdatavalid,
  output logic             acc_start,
  output logic [31:0]      acc_x,
  input  logic             acc_done,
  input  logic [31:0]      acc_y
);

  localparam int          CW       = (ADD_LAT < 1) ? 1 : $clog2(ADD_LAT + 1);
  localparam logic [CW-1:0] ADD_LAST = CW'(ADD_LAT);

  seq_state_t       r_state, w_next;
  logic [31:0]      r_base;
  logic [CNT_W-1:0] r_n;
  logic [CNT_W-1:0] r_proc_cnt;
  logic [31:0]      r_sum;
  logic [31:0]      r_result;
  logic [31:0]      r_y;
  logic [31:0]      r_acc_x;
  logic             r_acc_start;
  logic [CW-1:0]    r_add_cnt;
  logic             w_take;
  logic             w_add_done;
  logic             w_start_ok;
  logic             w_buf_valid;
  logic [31:0]      w_buf_data;
  logic [31:0]      w_fp_q;

  assign w_start_ok = (r_state == IDLE) && start;

  vec_fetch_unit #(
    .CNT_W  (CNT_W),
    .STRIDE (STRIDE)
  ) u_fetch (
    .clk               (clk),
    .reset             (reset),
    .clear             (w_start_ok),
    .base_addr         (r_base),
    .n_elem            (r_n),
    .take              (w_take),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .buf_valid         (w_buf_valid),
    .buf_data          (w_buf_data)
  );

  // Operands sum and y stay stable for the whole ACCUM window
  fp_add #(
    .LAT (ADD_LAT)
  ) u_add (
    .clk    (clk),
    .areset (reset),
    .a      (r_sum),
    .b      (r_y),
    .q      (w_fp_q)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state and control decode
  always_comb begin
    w_next     = r_state;
    w_take     = 1'b0;
    w_add_done = 1'b0;
    unique case (r_state)
      IDLE:    if (start) w_next = (n_elem == '0) ? FINISH : LAUNCH;
      LAUNCH:  if (w_buf_valid) begin
                 w_take = 1'b1;
                 w_next = COMPUTE;
               end
      COMPUTE: if (acc_done) w_next = ACCUM;
      ACCUM:   if (r_add_cnt == ADD_LAST) begin
                 w_add_done = 1'b1;
                 w_next     = ((r_proc_cnt + CNT_W'(1)) < r_n) ? LAUNCH : FINISH;
               end
      FINISH:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath: operand latch, accelerator handoff, accumulation, result
  always_ff @(posedge clk) begin
    if (reset) begin
      r_base      <= 32'h0;
      r_n         <= '0;
      r_proc_cnt  <= '0;
      r_sum       <= FP_ZERO;
      r_result    <= FP_ZERO;
      r_y         <= 32'h0;
      r_acc_x     <= 32'h0;
      r_acc_start <= 1'b0;
      r_add_cnt   <= '0;
    end else begin
      r_acc_start <= w_take;
      case (r_state)
        IDLE: if (start) begin
          r_base     <= base_addr & 32'hFFFF_FFFC;
          r_n        <= n_elem;
          r_proc_cnt <= '0;
          r_sum      <= FP_ZERO;
        end
        LAUNCH: if (w_buf_valid) r_acc_x <= w_buf_data;
        COMPUTE: begin
          r_add_cnt <= '0;
          if (acc_done) r_y <= acc_y;
        end
        ACCUM: begin
          if (w_add_done) begin
            r_sum      <= w_fp_q;
            r_proc_cnt <= r_proc_cnt + CNT_W'(1);
          end else begin
            r_add_cnt  <= r_add_cnt + CW'(1);
          end
        end
        FINISH: r_result <= r_sum;
        default: ;
      endcase
    end
  end

  // The sum is presented directly during the done cycle, then held
  assign done      = (r_state == FINISH);
  assign result    = done ? r_sum : r_result;
  assign acc_start = r_acc_start;
  assign acc_x     = r_acc_x;

endmodule
`default_nettype wire

// File: tb/tb_vec_accel_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_vec_accel_sequencer
// Description : Directed self-checking bench with memory slave, accelerator
//               stub and a real-valued reference model of the vector sum
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vec_accel_sequencer;
  import vec_accel_pkg::*;

  localparam int ACC_LAT = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = 32'h0;
  logic [15:0] n_elem = 16'h0;
  logic        done;
  logic [31:0] result;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic        acc_start;
  logic [31:0] acc_x;
  logic        acc_done;
  logic [31:0] acc_y;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  vec_accel_sequencer #(.ADD_LAT(3), .CNT_W(16), .STRIDE(4)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .n_elem(n_elem),
    .done(done), .result(result),
    .avm_address(avm_address), .avm_read(avm_read), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .acc_start(acc_start), .acc_x(acc_x), .acc_done(acc_done), .acc_y(acc_y)
  );

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic real f32_to_real(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == 31'd0) return 0.0;
    d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] real_to_f32(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // Accelerator behaviour: mode 0 is identity, mode 1 doubles x
  function automatic logic [31:0] stub_f(input int fm, input logic [31:0] x);
    if (fm == 1) return real_to_f32(2.0 * f32_to_real(x));
    return x;
  endfunction

  // Memory slave state
  logic [31:0] mem [int];
  int          wmax = 0, dmin = 1, dmax = 1;
  bit          in_req = 1'b0, granting = 1'b0, rsp_pend = 1'b0;
  int          wait_left = 0, rsp_delay = 0, reads_seen = 0;
  logic [31:0] req_addr = 32'h0, rsp_data = 32'h0;
  logic [31:0] seen_addr [$];

  // Accelerator stub state
  bit          acc_busy = 1'b0;
  int          acc_left = 0, n_launch = 0, fmode = 0;
  logic [31:0] acc_xl = 32'h0;
  logic [31:0] x_seen [$];

  // Reference state
  int          done_cnt = 0;
  logic [31:0] exp_result = 32'h0, model_result = 32'h0;
  logic [31:0] vec [$];

  // Avalon slave: random stall, accept, delayed single-beat response
  initial begin
    avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = 32'h0;
    forever begin
      @(negedge clk);
      avm_readdatavalid = 1'b0;
      if (granting) begin
        granting = 1'b0; in_req = 1'b0;
        seen_addr.push_back(req_addr);
        rsp_data  = mem.exists(int'(req_addr >> 2)) ? mem[int'(req_addr >> 2)] : 32'hDEAD_BEEF;
        rsp_delay = int'($urandom_range(dmax, dmin));
        rsp_pend  = 1'b1;
      end
      if (rsp_pend) begin
        rsp_delay--;
        if (rsp_delay <= 0) begin
          avm_readdatavalid = 1'b1; avm_readdata = rsp_data; rsp_pend = 1'b0;
        end
      end
      avm_waitrequest = 1'b0;
      if (reset) begin
        in_req = 1'b0;
      end else if (avm_read) begin
        if (!in_req) begin
          in_req = 1'b1; req_addr = avm_address; reads_seen++;
          wait_left = int'($urandom_range(wmax, 0));
        end else begin
          check32("addr_stable", avm_address, req_addr);
        end
        if (wait_left > 0) begin
          avm_waitrequest = 1'b1; wait_left--;
        end else begin
          granting = 1'b1;
        end
      end else if (in_req) begin
        check32("read_held", 32'(avm_read), 32'd1);
        in_req = 1'b0;
      end
    end
  end

  // Accelerator stub with fixed latency, checks x stays put while busy
  initial begin
    acc_done = 1'b0; acc_y = 32'h0;
    forever begin
      @(negedge clk);
      acc_done = 1'b0;
      if (reset) begin
        acc_busy = 1'b0;
      end else begin
        if (acc_busy) begin
          check32("acc_x_hold", acc_x, acc_xl);
          acc_left--;
          if (acc_left == 0) begin
            acc_done = 1'b1; acc_y = stub_f(fmode, acc_xl); acc_busy = 1'b0;
          end
        end
        if (acc_start) begin
          acc_busy = 1'b1; acc_xl = acc_x; acc_left = ACC_LAT;
          n_launch++; x_seen.push_back(acc_x);
        end
      end
    end
  end

  // Compare process: result at every done pulse, and held value otherwise
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        model_result = 32'h0;
      end else if (done) begin
        done_cnt++;
        check32("result_at_done", result, exp_result);
        model_result = exp_result;
      end else begin
        check32("result_hold", result, model_result);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start(input logic [31:0] b, input logic [15:0] n);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; n_elem = n;
    @(posedge clk); #1;
    start = 1'b0; base_addr = 32'hFFFF_FFF0; n_elem = 16'hFFFF;
  endtask

  task automatic run_op(input logic [31:0] base, input int fm, input logic [31:0] lit,
                        input bit glitch);
    real         s;
    logic [31:0] exp_addr [$];
    int          n;
    bit          got;
    n = vec.size();
    s = 0.0;
    fmode = fm;
    for (int i = 0; i < n; i++) begin
      mem[int'(base >> 2) + i] = vec[i];
      s = s + f32_to_real(stub_f(fm, vec[i]));
      exp_addr.push_back(base + 32'(4 * i));
    end
    exp_result = real_to_f32(s);
    check32("model_pin", exp_result, lit);
    seen_addr.delete(); x_seen.delete(); done_cnt = 0; n_launch = 0;
    pulse_start(base, 16'(n));
    if (glitch) begin
      got = 1'b0;
      for (int c = 0; c < 2000 && !got; c++) begin @(negedge clk); got = acc_busy; end
      pulse_start(32'h2000, 16'd1);
    end
    got = 1'b0;
    for (int c = 0; c < 4000 && !got; c++) begin @(negedge clk); got = (done_cnt != 0); end
    check32("done_seen", 32'(got), 32'd1);
    repeat (6) @(negedge clk);
    check32("done_pulses", 32'(done_cnt), 32'd1);
    check32("launch_count", 32'(n_launch), 32'(n));
    check32("addr_count", 32'(seen_addr.size()), 32'(n));
    for (int i = 0; i < n && i < seen_addr.size(); i++)
      check32("addr_seq", seen_addr[i], exp_addr[i]);
    for (int i = 0; i < n && i < x_seen.size(); i++)
      check32("acc_x_operand", x_seen[i], vec[i]);
  endtask

  initial begin
    bit got;
    int rd_before;
    mem[int'(32'h2000 >> 2)] = 32'h4480_0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check32("rst_done", 32'(done), 32'd0);
    check32("rst_result", result, 32'h0);
    check32("rst_avm_read", 32'(avm_read), 32'd0);
    check32("rst_avm_address", avm_address, 32'h0);
    check32("rst_acc_start", 32'(acc_start), 32'd0);
    check32("rst_acc_x", acc_x, 32'h0);
    @(posedge clk); #1 reset = 1'b0;

    // Empty vector: done the cycle after start, no bus activity
    done_cnt = 0; exp_result = 32'h0; reads_seen = 0;
    @(posedge clk); #1; start = 1'b1; base_addr = 32'h5000; n_elem = 16'd0;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    check32("n0_done_at_plus1", 32'(done), 32'd1);
    check32("n0_result", result, 32'h0);
    repeat (4) @(negedge clk);
    check32("n0_done_pulses", 32'(done_cnt), 32'd1);
    check32("n0_no_reads", 32'(reads_seen), 32'd0);

    // [1,2,3,4] identity, ideal memory
    vec = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
    run_op(32'h1000, 0, 32'h4120_0000, 1'b0);

    // Same vector with stalls and delayed read data
    wmax = 5; dmin = 1; dmax = 8;
    run_op(32'h1000, 0, 32'h4120_0000, 1'b0);

    // Doubling accelerator, mixed signs: 3.0 - 0.5 + 6.0 = 8.5
    vec = '{32'h3FC0_0000, 32'hBE80_0000, 32'h4040_0000};
    run_op(32'h6000, 1, 32'h4108_0000, 1'b0);

    // Second start during COMPUTE must be ignored
    wmax = 0; dmin = 1; dmax = 1;
    vec = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
    run_op(32'h1000, 0, 32'h4120_0000, 1'b1);

    // Reset in COMPUTE of element 2 with the next read still outstanding
    dmin = 30; dmax = 30; fmode = 0;
    mem[int'(32'h3000 >> 2)]     = 32'h3F80_0000;
    mem[int'(32'h3000 >> 2) + 1] = 32'h3F80_0000;
    mem[int'(32'h3000 >> 2) + 2] = 32'h4200_0000;
    seen_addr.delete(); x_seen.delete(); n_launch = 0; done_cnt = 0;
    pulse_start(32'h3000, 16'd3);
    got = 1'b0;
    for (int c = 0; c < 3000 && !got; c++) begin @(negedge clk); got = (n_launch >= 2); end
    check32("reached_elem2", 32'(got), 32'd1);
    repeat (5) @(negedge clk);
    check32("prefetch_issued", 32'(seen_addr.size()), 32'd3);
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check32("mid_rst_done", 32'(done), 32'd0);
    check32("mid_rst_result", result, 32'h0);
    check32("mid_rst_avm_read", 32'(avm_read), 32'd0);
    check32("mid_rst_acc_start", 32'(acc_start), 32'd0);
    check32("mid_rst_acc_x", acc_x, 32'h0);
    rd_before = reads_seen;
    got = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin @(negedge clk); got = !rsp_pend; end
    check32("stale_rdv_sent", 32'(got), 32'd1);
    repeat (4) @(negedge clk);
    check32("stale_no_new_read", 32'(reads_seen), 32'(rd_before));
    check32("stale_no_done", 32'(done_cnt), 32'd0);
    dmin = 1; dmax = 1;
    vec = '{32'h3F80_0000, 32'h3F80_0000};
    run_op(32'h4000, 0, 32'h4000_0000, 1'b0);

    // Empty vector after a real result: result returns to zero
    vec = {};
    run_op(32'h7000, 0, 32'h0000_0000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
